// File: rtl/led_sweep_counter.sv
// led_sweep_counter: prescaled LED index counter with stop, wrap and bounce sweep modes.
module led_sweep_counter #(
  parameter int WIDTH = 5,
  parameter int DIV_W = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] start_num,
  input  logic [WIDTH-1:0] end_num,
  input  logic             up_down,
  input  logic [1:0]       mode,
  input  logic             load,
  input  logic             enable,
  input  logic [DIV_W-1:0] div,
  output logic [WIDTH-1:0] counter_out,
  output logic             dir,
  output logic             check,
  output logic             turn
);
  logic [DIV_W-1:0] count;
  logic [WIDTH-1:0] lo, hi, n_cnt;
  logic             tick, stop, wrap, bounce, at_bnd, oor, d_follow, n_dir, n_check, n_turn;
  always_comb begin
    lo       = (start_num < end_num) ? start_num : end_num;
    hi       = (start_num < end_num) ? end_num : start_num;
    tick     = enable && (count == div);
    stop     = mode[1] == mode[0];
    wrap     = mode == 2'b01;
    bounce   = mode == 2'b10;
    oor      = (counter_out < lo) || (counter_out > hi);
    at_bnd   = dir ? (counter_out == hi) : (counter_out == lo);
    d_follow = bounce ? dir : up_down;
    n_cnt    = counter_out;
    n_dir    = d_follow;
    n_check  = 1'b0;
    n_turn   = 1'b0;
    if (oor)
      n_cnt = dir ? lo : hi;
    else if (lo == hi) begin
      n_cnt   = lo;
      n_check = stop;
    end else if (!at_bnd)
      n_cnt = dir ? counter_out + 1'b1 : counter_out - 1'b1;
    else if (stop)
      n_check = 1'b1;
    else if (wrap) begin
      n_cnt  = dir ? lo : hi;
      n_turn = 1'b1;
    end else begin
      // bounce reversal: flip and take the first step back on the same tick
      n_dir  = !dir;
      n_cnt  = dir ? counter_out - 1'b1 : counter_out + 1'b1;
      n_turn = 1'b1;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      counter_out <= '0;
      dir         <= 1'b1;
      check       <= 1'b1;
      turn        <= 1'b0;
      count       <= '0;
    end else if (load) begin
      counter_out <= start_num;
      dir         <= up_down;
      check       <= 1'b0;
      turn        <= 1'b0;
      count       <= '0;
    end else begin
      turn <= tick && n_turn;
      if (enable) begin
        count <= tick ? '0 : count + 1'b1;
        dir   <= tick ? n_dir : d_follow;
        if (tick) begin
          counter_out <= n_cnt;
          check       <= n_check;
        end
      end
    end
  end
endmodule

// File: tb/tb_led_sweep_counter.sv
// tb_led_sweep_counter: directed scenario bench for led_sweep_counter.
module tb_led_sweep_counter;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [4:0]  start_num = '0, end_num = '0, counter_out;
  logic        up_down = 1'b1, load = 1'b0, enable = 1'b0, dir, check, turn;
  logic [1:0]  mode = 2'b00;
  logic [23:0] div = '0;
  int checks = 0, errors = 0;
  led_sweep_counter #(.WIDTH(5), .DIV_W(24)) dut (
    .clk(clk), .rst(rst), .start_num(start_num), .end_num(end_num), .up_down(up_down),
    .mode(mode), .load(load), .enable(enable), .div(div),
    .counter_out(counter_out), .dir(dir), .check(check), .turn(turn)
  );
  always #5 clk = ~clk;
  task automatic edge1();
    @(posedge clk);
    #1;
  endtask
  task automatic do_load(input logic [4:0] s, input logic [4:0] e, input logic ud, input logic [1:0] m);
    start_num = s; end_num = e; up_down = ud; mode = m; load = 1'b1;
    edge1();
    load = 1'b0;
  endtask
  task automatic test_reset();
    rst = 1'b1;
    edge1();
    checks++;
    if ({counter_out, dir, check, turn} !== {5'd0, 3'b110}) begin
      errors++;
      $display("FAIL reset: got cnt=%0d dir=%0b chk=%0b turn=%0b want 0 1 1 0", counter_out, dir, check, turn);
    end
    rst = 1'b0;
    enable = 1'b1;
  endtask
  task automatic test_stop();
    int ec1[5] = '{4, 5, 6, 7, 7};
    int ck1[5] = '{0, 0, 0, 0, 1};
    int ec2[6] = '{7, 6, 5, 4, 3, 3};
    int ck2[6] = '{1, 0, 0, 0, 0, 1};
    div = '0;
    do_load(5'd3, 5'd7, 1'b1, 2'b00);
    checks++;
    if (counter_out !== 5'd3 || check !== 1'b0) begin
      errors++;
      $display("FAIL stop_load: got cnt=%0d chk=%0b want 3 0", counter_out, check);
    end
    for (int i = 0; i < 5; i++) begin
      edge1();
      checks++;
      if (counter_out !== 5'(ec1[i]) || check !== 1'(ck1[i])) begin
        errors++;
        $display("FAIL stop_up[%0d]: got cnt=%0d chk=%0b want %0d %0d", i, counter_out, check, ec1[i], ck1[i]);
      end
    end
    up_down = 1'b0;
    for (int i = 0; i < 6; i++) begin
      edge1();
      checks++;
      if (counter_out !== 5'(ec2[i]) || check !== 1'(ck2[i])) begin
        errors++;
        $display("FAIL stop_down[%0d]: got cnt=%0d chk=%0b want %0d %0d", i, counter_out, check, ec2[i], ck2[i]);
      end
    end
  endtask
  task automatic test_wrap();
    int eu[4] = '{3, 4, 2, 3};
    int ed[4] = '{3, 2, 4, 3};
    int et[4] = '{0, 0, 1, 0};
    do_load(5'd2, 5'd4, 1'b1, 2'b01);
    checks++;
    if (counter_out !== 5'd2 || turn !== 1'b0) begin
      errors++;
      $display("FAIL wrap_load_up: got cnt=%0d turn=%0b want 2 0", counter_out, turn);
    end
    for (int i = 0; i < 4; i++) begin
      edge1();
      checks++;
      if (counter_out !== 5'(eu[i]) || turn !== 1'(et[i]) || check !== 1'b0) begin
        errors++;
        $display("FAIL wrap_up[%0d]: got cnt=%0d turn=%0b chk=%0b want %0d %0d 0", i, counter_out, turn, check, eu[i], et[i]);
      end
    end
    do_load(5'd4, 5'd2, 1'b0, 2'b01);
    checks++;
    if (counter_out !== 5'd4 || dir !== 1'b0) begin
      errors++;
      $display("FAIL wrap_load_down: got cnt=%0d dir=%0b want 4 0", counter_out, dir);
    end
    for (int i = 0; i < 4; i++) begin
      edge1();
      checks++;
      if (counter_out !== 5'(ed[i]) || turn !== 1'(et[i])) begin
        errors++;
        $display("FAIL wrap_down[%0d]: got cnt=%0d turn=%0b want %0d %0d", i, counter_out, turn, ed[i], et[i]);
      end
    end
  endtask
  task automatic test_bounce();
    int ec[5] = '{2, 3, 2, 1, 2};
    int ed[5] = '{1, 1, 0, 0, 1};
    int et[5] = '{0, 0, 1, 0, 1};
    do_load(5'd1, 5'd3, 1'b1, 2'b10);
    up_down = 1'b0;
    checks++;
    if (counter_out !== 5'd1 || dir !== 1'b1) begin
      errors++;
      $display("FAIL bounce_load: got cnt=%0d dir=%0b want 1 1", counter_out, dir);
    end
    for (int i = 0; i < 5; i++) begin
      edge1();
      checks++;
      if (counter_out !== 5'(ec[i]) || dir !== 1'(ed[i]) || turn !== 1'(et[i]) || check !== 1'b0) begin
        errors++;
        $display("FAIL bounce[%0d]: got cnt=%0d dir=%0b turn=%0b chk=%0b want %0d %0d %0d 0",
                 i, counter_out, dir, turn, check, ec[i], ed[i], et[i]);
      end
    end
  endtask
  task automatic test_prescaler();
    int ec[7] = '{0, 0, 1, 1, 1, 2, 2};
    div = 24'd2;
    do_load(5'd0, 5'd31, 1'b1, 2'b00);
    for (int i = 0; i < 7; i++) begin
      edge1();
      checks++;
      if (counter_out !== 5'(ec[i])) begin
        errors++;
        $display("FAIL presc[%0d]: got cnt=%0d want %0d", i, counter_out, ec[i]);
      end
    end
    enable = 1'b0;
    for (int i = 0; i < 5; i++) begin
      edge1();
      checks++;
      if (counter_out !== 5'd2 || turn !== 1'b0) begin
        errors++;
        $display("FAIL presc_frozen[%0d]: got cnt=%0d turn=%0b want 2 0", i, counter_out, turn);
      end
    end
    enable = 1'b1;
    edge1();
    checks++;
    if (counter_out !== 5'd2) begin
      errors++;
      $display("FAIL presc_resume1: got cnt=%0d want 2", counter_out);
    end
    edge1();
    checks++;
    if (counter_out !== 5'd3) begin
      errors++;
      $display("FAIL presc_resume2: got cnt=%0d want 3", counter_out);
    end
    div = '0;
  endtask
  task automatic test_bounds();
    do_load(5'd5, 5'd5, 1'b1, 2'b10);
    for (int i = 0; i < 3; i++) begin
      edge1();
      checks++;
      if (counter_out !== 5'd5 || turn !== 1'b0) begin
        errors++;
        $display("FAIL equal_bounds[%0d]: got cnt=%0d turn=%0b want 5 0", i, counter_out, turn);
      end
    end
    do_load(5'd0, 5'd0, 1'b1, 2'b00);
    checks++;
    if (counter_out !== 5'd0) begin
      errors++;
      $display("FAIL zero_load: got cnt=%0d want 0", counter_out);
    end
    start_num = 5'd10;
    end_num = 5'd20;
    edge1();
    checks++;
    if (counter_out !== 5'd10 || check !== 1'b0) begin
      errors++;
      $display("FAIL out_of_range: got cnt=%0d chk=%0b want 10 0", counter_out, check);
    end
    edge1();
    checks++;
    if (counter_out !== 5'd11) begin
      errors++;
      $display("FAIL after_oor: got cnt=%0d want 11", counter_out);
    end
  endtask
  task automatic test_reset_midrun();
    do_load(5'd1, 5'd3, 1'b1, 2'b10);
    edge1();
    edge1();
    edge1();
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({counter_out, dir, check, turn} !== {5'd0, 3'b110}) begin
      errors++;
      $display("FAIL async_reset: got cnt=%0d dir=%0b chk=%0b turn=%0b want 0 1 1 0", counter_out, dir, check, turn);
    end
    edge1();
    rst = 1'b0;
    do_load(5'd1, 5'd3, 1'b1, 2'b10);
    edge1();
    checks++;
    if (counter_out !== 5'd2 || dir !== 1'b1) begin
      errors++;
      $display("FAIL post_reset: got cnt=%0d dir=%0b want 2 1", counter_out, dir);
    end
  endtask
  initial begin
    test_reset();
    test_stop();
    test_wrap();
    test_bounce();
    test_prescaler();
    test_bounds();
    test_reset_midrun();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/led_sweep_counter.md
# led_sweep_counter

Parametrised LED position counter for the LED display path. It steps an index between two run-time bounds at a programmable rate, in one of three modes: stop at bound, wrap around, or bounce (ping-pong). Outputs are the current index, a stop-mode bound flag and a one-cycle turn/wrap event. It replaces the fixed 5-bit up/down bound counter and adds load, enable, a prescaler and wrap/bounce behaviour.

## Interface
- WIDTH, 5: index width; start_num, end_num and counter_out are WIDTH bits.
- DIV_W, 24: prescaler divider width.
- clk  in  1  single clock; all state updates on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- start_num  in  WIDTH  load value and first range bound.
- end_num  in  WIDTH  second range bound.
- up_down  in  1  1 = count up, 0 = count down.
- mode  in  2  00 stop, 01 wrap, 10 bounce, 11 treated as stop.
- load  in  1  synchronous load strobe.
- enable  in  1  run enable; 0 freezes the prescaler and the counter.
- div  in  DIV_W  step period minus one, in clk cycles.
- counter_out  out  WIDTH  current index.
- dir  out  1  current direction; 1 = up.
- check  out  1  stop mode only: set when a tick finds the index already at its bound.
- turn  out  1  one-cycle pulse on a wrap tick or a bounce reversal tick.

## Operation
- lo = min(start_num, end_num) and hi = max(start_num, end_num). Both are combinational from the live inputs.
- Priority: rst > load > tick.
- rst: counter_out=0, dir=1, check=1, turn=0, prescaler count=0.
- load: counter_out<=start_num, dir<=up_down, check<=0, turn<=0, prescaler count<=0. Load applies regardless of enable.
- Prescaler: when enable=1, the count increments each cycle. tick = enable && (count == div); on a tick the count returns to 0. div=0 gives a tick every cycle.
- turn defaults to 0 on every cycle that is not a turn/wrap tick.
- Stop and wrap modes: dir follows up_down every cycle (registered).
- Bounce mode: dir changes only on load or on a reversal.
- Out-of-range index (counter_out < lo or > hi, e.g. after a bound change): on the next tick counter_out<=lo if dir=1, else hi. check=0, turn=0, in every mode.
- Stop mode on a tick:
  - If dir=1 and counter_out<hi: +1, check<=0.
  - If dir=0 and counter_out>lo: -1, check<=0.
  - Otherwise hold, check<=1.
- Wrap mode on a tick:
  - Step as in stop mode.
  - At hi going up: counter_out<=lo, turn<=1.
  - At lo going down: counter_out<=hi, turn<=1.
  - check stays 0.
- Bounce mode on a tick:
  - Step toward hi (dir=1) or lo (dir=0).
  - At the bound: dir inverts, counter_out moves one step in the new direction on the same tick, turn<=1.
  - check stays 0.
- lo == hi in any mode: index holds at lo and turn=0. Stop mode still sets check=1.
- Arithmetic is WIDTH bits unsigned. The bound checks above ensure no wrap through 0 or 2^WIDTH-1 ever occurs.

## Timing
- All outputs are registered. No combinational path runs from inputs to outputs.
- Reset asserts asynchronously: outputs take reset values without waiting for a clk edge. Release is synchronous to the next rising edge.
- After load (or enable rising with count=0), the first step occurs on the (div+1)-th rising edge. Subsequent steps occur every div+1 cycles.
- enable=0 holds the count, index, dir and check; turn drops to 0.
- A div change takes effect immediately. If count > new div, the count runs on until it wraps at 2^DIV_W; the divider is not clamped.
- Changing mode mid-run takes effect at the next tick, starting from the current index and dir.

## Test plan
- Stop: div=0, mode=00, start=3, end=7, up_down=1, pulse load. Required: counter_out 3→4→5→6→7 on successive edges with check=0; the next edge keeps 7 with check=1. Then up_down=0: steps down to 3 and sets check again.
- Wrap: mode=01, start=2, end=4, up. Required: 2,3,4,2,3 with turn=1 only on the 4→2 edge. Down direction: 4,3,2,4 with turn on 2→4.
- Bounce: mode=10, start=1, end=3, load with up_down=1. Required: 1,2,3,2,1,2; turn pulses on 3→2 and 1→2; dir toggles at each pulse. up_down changes after load have no effect.
- Prescaler/enable: div=2, stop up, start=0, end=31. Required: steps every 3 cycles. Deassert enable for 5 cycles: counter_out and phase frozen; the step resumes exactly 3 enabled cycles after the last one.
- Boundaries: load with start=end=5 in bounce mode: holds 5, turn=0. With counter_out=0, set start=10, end=20, up, no load: next tick gives 10.
- Reset mid-run: assert rst between clk edges during bounce. Required: counter_out=0, dir=1, check=1, turn=0 before the next edge. After release, load resumes normal operation.
